// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue integer execute unit with valid/ready handshakes.
// Logic, arithmetic, compare and branch codes complete one cycle after acceptance.
// Shifts by a non-zero amount run through an iterative one-bit-per-cycle shifter.
// Defining ALU_EXEC_BARREL_SHIFT_EN replaces that with a combinational barrel
// shifter, so every code completes in one cycle. Results are the same in both builds.
//
// state | meaning
// IDLE  | waiting for a request, o_ready high
// SHIFT | iterative shift in progress, one bit per cycle
// DONE  | result presented on o_valid, held until i_ready
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [4:0]            i_alu_ctrl,
  input  logic [DATA_WIDTH-1:0] i_src_a,
  input  logic [DATA_WIDTH-1:0] i_src_b,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_branch_taken,
  output logic                  o_illegal
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

`ifdef ALU_EXEC_BARREL_SHIFT_EN
  localparam bit ITER_SHIFT = 1'b0;
`else
  localparam bit ITER_SHIFT = 1'b1;
`endif

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_XOR  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SLL  = 5'b00101;
  localparam logic [4:0] OP_SRL  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_SLTU = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01001;
  localparam logic [4:0] OP_BEQ  = 5'b01010;
  localparam logic [4:0] OP_BNE  = 5'b01011;
  localparam logic [4:0] OP_BLT  = 5'b01100;
  localparam logic [4:0] OP_BLTU = 5'b01101;
  localparam logic [4:0] OP_BGE  = 5'b01110;
  localparam logic [4:0] OP_BGEU = 5'b01111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d;
  logic                  branch_q, branch_d;
  logic                  illegal_q, illegal_d;

  logic [SHAMT_W-1:0]    shamt_in;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_br;
  logic                  alu_ill;
  logic                  is_shift_in;
  logic                  start_iter;
  logic                  accept;
  logic [DATA_WIDTH-1:0] shift_step;

  assign shamt_in    = i_src_b[SHAMT_W-1:0];
  // Reset must hold o_ready low even though the state is already IDLE.
  assign o_ready     = (state_q == IDLE) && !i_rst;
  assign accept      = i_valid && o_ready;
  assign is_shift_in = (i_alu_ctrl == OP_SLL) || (i_alu_ctrl == OP_SRL) ||
                       (i_alu_ctrl == OP_SRA);
  assign start_iter  = ITER_SHIFT && is_shift_in && (shamt_in != '0);

  assign o_valid        = (state_q == DONE);
  assign o_result       = result_q;
  assign o_branch_taken = branch_q;
  assign o_illegal      = illegal_q;

  // Single-cycle datapath on the incoming operands; shifts by zero pass i_src_a.
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ill = 1'b0;
    case (i_alu_ctrl)
      OP_AND:  alu_res = i_src_a & i_src_b;
      OP_OR:   alu_res = i_src_a | i_src_b;
      OP_XOR:  alu_res = i_src_a ^ i_src_b;
      OP_ADD:  alu_res = i_src_a + i_src_b;
      OP_SUB:  alu_res = i_src_a - i_src_b;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      OP_SLL:  alu_res = i_src_a << shamt_in;
      OP_SRL:  alu_res = i_src_a >> shamt_in;
      OP_SRA:  alu_res = $signed(i_src_a) >>> shamt_in;
`else
      OP_SLL:  alu_res = i_src_a;
      OP_SRL:  alu_res = i_src_a;
      OP_SRA:  alu_res = i_src_a;
`endif
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_src_a) < $signed(i_src_b))};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (i_src_a < i_src_b)};
      OP_BEQ:  alu_br  = (i_src_a == i_src_b);
      OP_BNE:  alu_br  = (i_src_a != i_src_b);
      OP_BLT:  alu_br  = ($signed(i_src_a) < $signed(i_src_b));
      OP_BLTU: alu_br  = (i_src_a < i_src_b);
      OP_BGE:  alu_br  = ($signed(i_src_a) >= $signed(i_src_b));
      OP_BGEU: alu_br  = (i_src_a >= i_src_b);
      default: alu_ill = 1'b1;
    endcase
  end

  // One-bit step of the iterative shifter; SRA replicates the sign bit.
  always_comb begin
    shift_step = shreg_q;
    case (op_q)
      OP_SLL:  shift_step = {shreg_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, shreg_q[DATA_WIDTH-1:1]};
      OP_SRA:  shift_step = {shreg_q[DATA_WIDTH-1], shreg_q[DATA_WIDTH-1:1]};
      default: shift_step = shreg_q;
    endcase
  end

  // Next-state logic: accept, shift countdown, then hold the result until consumed.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = i_alu_ctrl;
          if (start_iter) begin
            shreg_d   = i_src_a;
            cnt_d     = shamt_in;
            branch_d  = 1'b0;
            illegal_d = 1'b0;
            state_d   = SHIFT;
          end else begin
            result_d  = alu_res;
            branch_d  = alu_br;
            illegal_d = alu_ill;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        shreg_d = shift_step;
        cnt_d   = cnt_q - SHAMT_W'(1);
        // Last step lands in DONE together with the final shifted value.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = shift_step;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: behavioural reference model plus
// directed cases with hand-computed results, followed by random traffic.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [4:0]   i_alu_ctrl = '0;
  logic [W-1:0] i_src_a = '0;
  logic [W-1:0] i_src_b = '0;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [W-1:0] o_result;
  logic         o_branch_taken;
  logic         o_illegal;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.DATA_WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_ctrl(i_alu_ctrl), .i_src_a(i_src_a), .i_src_b(i_src_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_branch_taken(o_branch_taken), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: {illegal, branch, result} straight from the opcode table.
  function automatic logic [33:0] ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic br;
    logic ill;
    int sh;
    r = 0; br = 0; ill = 0; sh = int'(b[4:0]);
    case (op)
      5'd0:  r = a & b;
      5'd1:  r = a | b;
      5'd2:  r = a ^ b;
      5'd3:  r = a + b;
      5'd4:  r = a - b;
      5'd5:  r = a << sh;
      5'd6:  r = a >> sh;
      5'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd8:  r = (a < b) ? 32'd1 : 32'd0;
      5'd9:  r = $signed(a) >>> sh;
      5'd10: br = (a == b);
      5'd11: br = (a != b);
      5'd12: br = ($signed(a) < $signed(b));
      5'd13: br = (a < b);
      5'd14: br = ($signed(a) >= $signed(b));
      5'd15: br = (a >= b);
      default: ill = 1'b1;
    endcase
    return {ill, br, r};
  endfunction

  // Extra cycles beyond latency 1 for an accepted request.
  function automatic int extra_lat(input logic [4:0] op, input logic [31:0] b);
`ifdef ALU_EXEC_BARREL_SHIFT_EN
    return 0;
`else
    if ((op == 5'd5 || op == 5'd6 || op == 5'd9) && b[4:0] != 0) return int'(b[4:0]);
    return 0;
`endif
  endfunction

  // Model: pending flag, cycles until the result shows, and the expected result.
  logic        m_pend;
  int          m_cnt;
  logic [33:0] m_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_cnt  <= 0;
      m_exp  <= '0;
    end else if (!m_pend) begin
      if (i_valid) begin
        m_pend <= 1'b1;
        m_cnt  <= extra_lat(i_alu_ctrl, i_src_b);
        m_exp  <= ref_op(i_alu_ctrl, i_src_a, i_src_b);
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end else if (i_ready) begin
      m_pend <= 1'b0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst o_valid", o_valid, 0);
        chk("rst o_ready", o_ready, 0);
        chk("rst o_result", o_result, 0);
        chk("rst o_branch_taken", o_branch_taken, 0);
        chk("rst o_illegal", o_illegal, 0);
      end else begin
        chk("model o_ready", o_ready, !m_pend);
        chk("model o_valid", o_valid, m_pend && m_cnt == 0);
        if (m_pend && m_cnt == 0 && o_valid) begin
          chk("model o_result", o_result, m_exp[31:0]);
          chk("model o_branch_taken", o_branch_taken, m_exp[32]);
          chk("model o_illegal", o_illegal, m_exp[33]);
        end
      end
    end
  end

  task automatic wait_accept(input string nm, output bit got);
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (o_ready) got = 1;
    end
    chk({nm, " accepted"}, got, 1);
  endtask

  // Directed op with literal expectations; hold = cycles i_ready stays low while valid.
  task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input int elat,
                        input logic [31:0] er, input logic eb, input logic ei);
    bit got;
    int t;
    @(posedge clk); #1;
    i_valid = 1; i_alu_ctrl = op; i_src_a = a; i_src_b = b; i_ready = (hold == 0);
    wait_accept(nm, got);
    if (!got) begin i_valid = 0; return; end
    @(posedge clk); #1;
    i_valid = 0; i_src_a = $urandom; i_src_b = $urandom; i_alu_ctrl = 5'($urandom);
    got = 0; t = 0;
    for (int k = 0; k < 80 && !got; k++) begin
      @(negedge clk);
      t++;
      if (o_valid) got = 1;
    end
    chk({nm, " latency"}, t, elat);
    chk({nm, " result"}, o_result, er);
    chk({nm, " branch"}, o_branch_taken, eb);
    chk({nm, " illegal"}, o_illegal, ei);
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        chk({nm, " held valid"}, o_valid, 1);
        chk({nm, " held result"}, o_result, er);
        chk({nm, " held ready"}, o_ready, 0);
      end
      i_ready = 1;
    end
    @(negedge clk);
    chk({nm, " valid after handshake"}, o_valid, 0);
    chk({nm, " ready after handshake"}, o_ready, 1);
  endtask

  initial begin
    bit got;
    int o, r;
    logic [31:0] va;

    repeat (2) @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("ready after reset release", o_ready, 1);
    chk("valid after reset release", o_valid, 0);

    run_op("ADD wrap", 5'd3, 32'hFFFF_FFFF, 32'h1, 0, 1, 32'h0, 0, 0);
`ifdef ALU_EXEC_BARREL_SHIFT_EN
    run_op("SRA 4", 5'd9, 32'h8000_0000, 32'd4, 0, 1, 32'hF800_0000, 0, 0);
    run_op("SRL 31", 5'd6, 32'h8000_0000, 32'd31, 0, 1, 32'h1, 0, 0);
`else
    run_op("SRA 4", 5'd9, 32'h8000_0000, 32'd4, 0, 5, 32'hF800_0000, 0, 0);
    run_op("SRL 31", 5'd6, 32'h8000_0000, 32'd31, 0, 32, 32'h1, 0, 0);
`endif
    run_op("SLL shamt0", 5'd5, 32'h1234_5678, 32'd32, 0, 1, 32'h1234_5678, 0, 0);
    run_op("BLTU", 5'd13, 32'h1, 32'hFFFF_FFFF, 0, 1, 32'h0, 1, 0);
    run_op("BLT", 5'd12, 32'h1, 32'hFFFF_FFFF, 0, 1, 32'h0, 0, 0);
    run_op("SLT hold", 5'd7, 32'h5, 32'h5, 3, 1, 32'h0, 0, 0);
    run_op("illegal 10101", 5'd21, 32'hDEAD_BEEF, 32'h1, 0, 1, 32'h0, 0, 1);
    run_op("SUB under", 5'd4, 32'h0, 32'h1, 0, 1, 32'hFFFF_FFFF, 0, 0);
    run_op("BEQ", 5'd10, 32'hA5A5_0001, 32'hA5A5_0001, 0, 1, 32'h0, 1, 0);
    run_op("BGE", 5'd14, 32'hFFFF_FFFF, 32'h1, 0, 1, 32'h0, 0, 0);

    // Reset in the middle of a long shift discards it.
    @(posedge clk); #1;
    i_valid = 1; i_alu_ctrl = 5'd5; i_src_a = 32'h0000_0001; i_src_b = 32'd31; i_ready = 1;
    wait_accept("SLL reset", got);
    @(posedge clk); #1;
    i_valid = 0;
    repeat (10) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async rst o_valid", o_valid, 0);
    chk("async rst o_ready", o_ready, 0);
    chk("async rst o_result", o_result, 0);
    chk("async rst o_branch_taken", o_branch_taken, 0);
    chk("async rst o_illegal", o_illegal, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 0;
    @(negedge clk);
    chk("ready after mid-shift reset", o_ready, 1);
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_valid) got = 1;
    end
    chk("no valid after discarded shift", got, 0);

    // Random traffic checked by the compare process.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      i_valid = 1'($urandom_range(0, 1));
      o = int'($urandom_range(0, 19));
      i_alu_ctrl = (o < 16) ? 5'(o) : 5'($urandom_range(16, 31));
      r = int'($urandom_range(0, 5));
      va = (r == 0) ? 32'h8000_0000 : (r == 1) ? 32'hFFFF_FFFF : $urandom;
      i_src_a = va;
      r = int'($urandom_range(0, 7));
      i_src_b = (r == 0) ? va : (r == 1) ? 32'($urandom_range(0, 3)) :
                (r == 2) ? 32'hFFFF_FFFF : $urandom;
      i_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    i_valid = 0; i_ready = 1;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
